bin_fc: RTL and testbench
=========================

BIN_FC -- requirements
Module: bin_fc

Interface
REQ-001 Parameter NOUT, default 10: number of output neurons.
REQ-002 Parameter CHUNK, default 64: feature bits consumed per cycle; 960 divided by CHUNK SHALL be an integer (NCH = 960/CHUNK, default 15).
REQ-003 clk  input  1  sole clock; all state on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high (port name per codebase convention).
REQ-005 fmaps_in  input  logic [0:59][0:3][0:3]  binary feature maps from second pooling stage.
REQ-006 start  input  1  one-cycle request to classify the current fmaps_in.
REQ-007 w_addr  output  clog2(NOUT*NCH)  weight ROM word address.
REQ-008 w_en  output  1  weight read strobe.
REQ-009 w_rdata  input  CHUNK  weight word, valid the cycle after w_en (synchronous ROM).
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse; scores and class_out valid from that cycle.
REQ-012 scores  output  [0:NOUT-1] 11-bit  per-neuron result.
REQ-013 class_out  output  clog2(NOUT)  index of the maximum score.

Function
REQ-014 Flat bit index k = c*16 + r*4 + col; chunk j covers k = j*CHUNK .. j*CHUNK+CHUNK-1; w_rdata[i] pairs with bit j*CHUNK+i.
REQ-015 Weight word for neuron n, chunk j SHALL be at w_addr = n*NCH + j.
REQ-016 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN after the last address is issued; DRAIN->IDLE after the final accumulate.
REQ-017 On start sampled in IDLE, fmaps_in SHALL be captured into an internal 960-bit register; later changes to fmaps_in SHALL NOT affect the result.
REQ-018 In RUN, w_en high every cycle; w_addr steps 0,1,..,NOUT*NCH-1, one per cycle, with no gaps.
REQ-019 Each returned word: acc += popcount(XNOR(chunk, w_rdata)); acc cleared at chunk 0 of each neuron; width 11 bits, so no overflow is possible (max 960).
REQ-020 When chunk NCH-1 of neuron n is accumulated, scores[n] SHALL be written and a running max updated; a strictly greater score SHALL replace the max, so ties resolve to the lowest index.
REQ-021 Latency (defaults): done SHALL be registered at the 151st rising edge after the edge that sampled start; busy low in that same cycle.
REQ-022 start while busy SHALL be ignored; start in the cycle done is high SHALL be accepted.
REQ-023 scores and class_out SHALL hold until the next run writes them; scores are overwritten per neuron during that run.

Reset
REQ-024 rst_n high at an edge: state IDLE, busy=0, done=0, w_en=0, w_addr=0, all scores=0, class_out=0, accumulator and running max cleared.
REQ-025 Reset mid-run SHALL abort the run with no done pulse; a start in the first cycle after reset deasserts SHALL be accepted.

Configuration
REQ-026 Macro BIN_FC_BIPOLAR_EN: when defined, scores[n] = 2*popcount - 960 as signed two's-complement 11-bit (range -960..960), and argmax uses signed comparison.
REQ-027 When BIN_FC_BIPOLAR_EN is undefined, scores[n] = unsigned popcount zero-extended to 11 bits; class_out is identical in both builds for the same inputs.

Verification
REQ-028 All-ones fmaps, all-ones weights -> every score 960 (bipolar 960), class_out 0, done at edge 151.
REQ-029 All-ones fmaps, all-zero weights -> every score 0 (bipolar -960), class_out 0.
REQ-030 Neuron 7 weights equal the flattened fmaps, all other neurons' weights are the complement -> score7=960, others 0 (bipolar -960), class_out 7.
REQ-031 Neurons 3 and 5 both score 500, all others lower -> class_out 3.
REQ-032 start re-pulsed at cycle 50 -> ignored and done still at edge 151; separate run with rst_n high at cycle 80 -> busy 0, scores 0, no done pulse.
REQ-033 start held high in the done cycle -> second run accepted and done at edge 151 after that start; fmaps_in changed at cycle 10 of a run -> result unchanged.

Source files
------------

// File: rtl/bin_fc.sv
// Binary fully-connected classifier stage: XNOR-popcount of a 960-bit feature
// vector against NOUT weight rows streamed from a synchronous ROM, CHUNK bits
// per cycle, followed by an argmax over the per-neuron scores.
// Optional build macro: BIN_FC_BIPOLAR_EN selects signed bipolar scores
// (2*popcount - 960); undefined gives unsigned popcount scores.
// Note: rst_n is an active-high synchronous reset despite its name.
module bin_fc #(
  parameter int unsigned NOUT  = 10,
  parameter int unsigned CHUNK = 64,
  localparam int unsigned NCH  = 960 / CHUNK,
  localparam int unsigned AW   = $clog2(NOUT * NCH),
  localparam int unsigned CW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [0:59][0:3][0:3]     fmaps_in,
  input  logic                      start,
  output logic [AW-1:0]             w_addr,
  output logic                      w_en,
  input  logic [CHUNK-1:0]          w_rdata,
  output logic                      busy,
  output logic                      done,
  output logic [0:NOUT-1][10:0]     scores,
  output logic [CW-1:0]             class_out
);

  localparam int unsigned JW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = $clog2(CHUNK + 1);

  localparam logic [AW-1:0] LastAddr   = AW'(NOUT * NCH - 1);
  localparam logic [JW-1:0] LastChunk  = JW'(NCH - 1);
  localparam logic [CW-1:0] LastNeuron = CW'(NOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           r_state;
  logic [959:0]     r_feat;
  logic             r_vld;      // w_rdata holds a word requested last cycle
  logic [JW-1:0]    r_acc_j;    // chunk index of the word in w_rdata
  logic [CW-1:0]    r_acc_n;    // neuron index of the word in w_rdata
  logic [10:0]      r_acc;
  logic [10:0]      r_max;

  logic [959:0]     w_flat;
  int unsigned      w_base;
  logic [CHUNK-1:0] w_chunk;
  logic [CHUNK-1:0] w_xnor;
  logic [PW-1:0]    w_pc;
  logic [10:0]      w_acc_nxt;
  logic [10:0]      w_score;
  logic             w_take;
  logic             w_last_chunk;

  // Flatten the feature maps so that bit k = c*16 + r*4 + col.
  always_comb begin
    w_flat = '0;
    for (int c = 0; c < 60; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int col = 0; col < 4; col++) begin
          w_flat[c*16 + r*4 + col] = fmaps_in[c][r][col];
        end
      end
    end
  end

  // XNOR-popcount of the current chunk, accumulation and running-max decision.
  always_comb begin
    w_base  = int'(r_acc_j) * CHUNK;
    w_chunk = r_feat[w_base +: CHUNK];
    w_xnor  = ~(w_chunk ^ w_rdata);
    w_pc    = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      w_pc = w_pc + PW'(w_xnor[i]);
    end
    // Chunk 0 starts a fresh neuron, so the old accumulator is discarded.
    w_acc_nxt = ((r_acc_j == '0) ? 11'd0 : r_acc) + 11'(w_pc);
`ifdef BIN_FC_BIPOLAR_EN
    w_score = (w_acc_nxt << 1) - 11'd960;
    w_take  = (r_acc_n == '0) || ($signed(w_score) > $signed(r_max));
`else
    w_score = w_acc_nxt;
    w_take  = (r_acc_n == '0) || (w_score > r_max);
`endif
    w_last_chunk = r_vld && (r_acc_j == LastChunk);
  end

  // Control FSM with registered outputs, plus the score/argmax datapath.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= StIdle;
      r_feat    <= '0;
      r_vld     <= 1'b0;
      r_acc_j   <= '0;
      r_acc_n   <= '0;
      r_acc     <= '0;
      r_max     <= '0;
      w_addr    <= '0;
      w_en      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      scores    <= '0;
      class_out <= '0;
    end else begin
      done  <= 1'b0;
      r_vld <= w_en;

      if (r_vld) begin
        r_acc <= w_acc_nxt;
        if (r_acc_j == LastChunk) begin
          r_acc_j          <= '0;
          r_acc_n          <= r_acc_n + 1'b1;
          scores[r_acc_n]  <= w_score;
          if (w_take) begin
            r_max     <= w_score;
            class_out <= r_acc_n;
          end
        end else begin
          r_acc_j <= r_acc_j + 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StRun;
            r_feat  <= w_flat;
            busy    <= 1'b1;
            w_en    <= 1'b1;
            w_addr  <= '0;
            r_acc_j <= '0;
            r_acc_n <= '0;
            r_max   <= '0;
          end
        end
        StRun: begin
          if (w_addr == LastAddr) begin
            r_state <= StDrain;
            w_en    <= 1'b0;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        StDrain: begin
          if (w_last_chunk && (r_acc_n == LastNeuron)) begin
            r_state <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_fc.sv
// Self-checking bench for bin_fc: a table of feature/weight patterns with
// expected scores, a scoreboard queue popped on done, and hand-written
// sequences for re-pulsed start, start-in-done, input changes and mid-run reset.
// Honors BIN_FC_BIPOLAR_EN when computing expected scores.
module tb_bin_fc;

  localparam int NOUT  = 10;
  localparam int CHUNK = 64;
  localparam int NCH   = 15;
  localparam int NW    = NOUT * NCH;
  localparam int AW    = 8;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  start = 1'b0;
  logic [0:59][0:3][0:3] fmaps_in = '0;
  logic [AW-1:0]         w_addr;
  logic                  w_en;
  logic [CHUNK-1:0]      w_rdata = '0;
  logic                  busy;
  logic                  done;
  logic [0:NOUT-1][10:0] scores;
  logic [CW-1:0]         class_out;

  bin_fc #(.NOUT(NOUT), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fmaps_in  (fmaps_in),
    .start     (start),
    .w_addr    (w_addr),
    .w_en      (w_en),
    .w_rdata   (w_rdata),
    .busy      (busy),
    .done      (done),
    .scores    (scores),
    .class_out (class_out)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM.
  logic [CHUNK-1:0] rom [NW];
  always @(posedge clk) if (w_en) w_rdata <= rom[w_addr];

  typedef struct packed {
    logic [959:0]          feat;
    logic [2:0]            wmode;
    logic [0:NOUT-1][10:0] exp;
    logic [CW-1:0]         cls;
  } vec_t;

  typedef struct packed {
    logic [0:NOUT-1][10:0] sc;
    logic [CW-1:0]         cls;
  } res_t;

  vec_t             vecs [5];
  res_t             sb [$];
  logic [CHUNK-1:0] rnd_w [NW];
  int               cnt3 [NOUT] = '{100, 200, 300, 500, 400, 500, 0, 450, 499, 10};
  int               n_chk = 0;
  int               n_pass = 0;

  function automatic logic [10:0] sc(input int p);
`ifdef BIN_FC_BIPOLAR_EN
    return 11'(2 * p - 960);
`else
    return 11'(p);
`endif
  endfunction

  function automatic logic [959:0] rnd_feat();
    logic [959:0] f;
    for (int i = 0; i < 30; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_fmaps(input logic [959:0] f);
    for (int c = 0; c < 60; c++)
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          fmaps_in[c][r][col] = f[c*16 + r*4 + col];
  endtask

  // Load ROM and inputs for vector idx; optionally push its expected result.
  task automatic prep(input int idx, input bit push);
    logic [959:0] f;
    res_t         e;
    f = vecs[idx].feat;
    for (int a = 0; a < NW; a++) begin
      int n;
      int j;
      n = a / NCH;
      j = a % NCH;
      case (vecs[idx].wmode)
        3'd0: rom[a] = '1;
        3'd1: rom[a] = '0;
        3'd2: rom[a] = (n == 7) ? f[j*CHUNK +: CHUNK] : ~f[j*CHUNK +: CHUNK];
        3'd3: for (int i = 0; i < CHUNK; i++) rom[a][i] = ((j * CHUNK + i) < cnt3[n]);
        default: rom[a] = rnd_w[a];
      endcase
    end
    drive_fmaps(f);
    if (push) begin
      e.sc  = vecs[idx].exp;
      e.cls = vecs[idx].cls;
      sb.push_back(e);
    end
  endtask

  // Launch a run (caller sits #1 after an edge) and check it through done.
  task automatic do_run(input int idx, input int repulse, input int fchg, input bit in_done);
    int   lat;
    int   en_cnt;
    int   addr_err;
    bit   seen;
    res_t e;
    prep(idx, 1'b1);
    if (in_done) check("done_before_chained_start", 128'(done), 128'(1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; en_cnt = 0; addr_err = 0; seen = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    check("done_low_in_run", 128'(done), 128'(0));
    while (!seen && lat < 400) begin
      if (w_en) begin
        if (int'(w_addr) != en_cnt) addr_err++;
        en_cnt++;
      end
      start = (lat == repulse);
      if (lat == fchg) drive_fmaps(rnd_feat());
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_latency", 128'(lat), 128'(151));
    check("busy_low_at_done", 128'(busy), 128'(0));
    check("w_en_cycles", 128'(en_cnt), 128'(150));
    check("w_addr_gaps", 128'(addr_err), 128'(0));
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      check("scores", 128'(scores), 128'(e.sc));
      check("class_out", 128'(class_out), 128'(e.cls));
    end
  endtask

  initial begin
    int best;
    int dcnt;
    // Vector table.
    vecs[0].feat = '1;          vecs[0].wmode = 3'd0; vecs[0].cls = 4'd0;
    vecs[1].feat = '1;          vecs[1].wmode = 3'd1; vecs[1].cls = 4'd0;
    vecs[2].feat = rnd_feat();  vecs[2].wmode = 3'd2; vecs[2].cls = 4'd7;
    vecs[3].feat = '1;          vecs[3].wmode = 3'd3; vecs[3].cls = 4'd3;
    vecs[4].feat = rnd_feat();  vecs[4].wmode = 3'd4;
    for (int a = 0; a < NW; a++) rnd_w[a] = {$urandom, $urandom};
    best = -1;
    for (int n = 0; n < NOUT; n++) begin
      int pc;
      vecs[0].exp[n] = sc(960);
      vecs[1].exp[n] = sc(0);
      vecs[2].exp[n] = (n == 7) ? sc(960) : sc(0);
      vecs[3].exp[n] = sc(cnt3[n]);
      pc = 0;
      for (int k = 0; k < 960; k++)
        if (vecs[4].feat[k] == rnd_w[n*NCH + k/CHUNK][k%CHUNK]) pc++;
      vecs[4].exp[n] = sc(pc);
      if (pc > best) begin
        best = pc;
        vecs[4].cls = CW'(n);
      end
    end

    // Reset state.
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_w_en", 128'(w_en), 128'(0));
    check("rst_w_addr", 128'(w_addr), 128'(0));
    check("rst_scores", 128'(scores), 128'(0));
    check("rst_class", 128'(class_out), 128'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Table-driven runs.
    for (int i = 0; i < 5; i++) begin
      do_run(i, -1, -1, 1'b0);
      @(posedge clk); #1;
      check("done_one_cycle", 128'(done), 128'(0));
      check("scores_hold", 128'(scores), 128'(vecs[i].exp));
      repeat (2) @(posedge clk);
      #1;
    end

    // start re-pulsed mid-run is ignored.
    do_run(2, 50, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Inputs changed mid-run, then start held in the done cycle.
    do_run(4, -1, 10, 1'b0);
    do_run(3, -1, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset during a run aborts it; a start right after reset is accepted.
    prep(0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("abort_no_done_before", 128'(dcnt), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_w_en", 128'(w_en), 128'(0));
    check("abort_w_addr", 128'(w_addr), 128'(0));
    check("abort_scores", 128'(scores), 128'(0));
    check("abort_class", 128'(class_out), 128'(0));
    do_run(1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
